// File: rtl/ramdisk_block_buffer.sv
// One-block (WORDS x 16-bit) staging buffer and command sequencer between the
// host-side disk-controller datapath and the SDRAM RAM-disk engine.
module ramdisk_block_buffer #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic        ramclk,
  input  logic        reset_n,
  input  logic        host_cmd_valid,
  input  logic        host_cmd_write,
  input  logic [31:0] host_block_addr,
  output logic        host_cmd_ready,
  input  logic [15:0] host_wdata,
  input  logic        host_wvalid,
  output logic        host_wready,
  output logic [15:0] host_rdata,
  output logic        host_rvalid,
  input  logic        host_rready,
  output logic        op_done,
  output logic        op_error,
  input  logic        command_ready,
  output logic        read_cmd,
  output logic        write_cmd,
  output logic [31:0] block_address,
  output logic [15:0] write_data,
  input  logic        write_data_enable,
  input  logic [15:0] read_data,
  input  logic        read_data_enable
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_ISSUE_W, S_ISSUE_R, S_WAIT_W, S_WAIT_R, S_DRAIN, S_DONE
  } state_t;

  localparam logic [AW:0] LP_FULL = (AW+1)'(WORDS);
  localparam logic [AW:0] LP_LAST = (AW+1)'(WORDS - 1);
  localparam logic [AW:0] LP_ONE  = (AW+1)'(1);

  state_t      r_state;
  state_t      w_state_next;
  logic [AW:0] r_ptr;
  logic [31:0] r_block_address;
  logic        r_op_error;
  logic [15:0] r_mem [WORDS];

  // The extra pointer MSB marks a full block; beats are refused once it is set.
  logic w_full;
  logic w_ptr_last;
  logic w_wr_beat;
  logic w_rd_beat;
  logic w_rd_store;

  assign w_full     = r_ptr[AW];
  assign w_ptr_last = (r_ptr == LP_LAST);
  assign w_wr_beat  = (r_state == S_FILL)   && host_wvalid && !w_full;
  assign w_rd_beat  = (r_state == S_DRAIN)  && host_rready && !w_full;
  assign w_rd_store = (r_state == S_WAIT_R) && read_data_enable && !w_full;

  always_ff @(posedge ramclk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    w_state_next   = r_state;
    host_cmd_ready = 1'b0;
    host_wready    = 1'b0;
    host_rvalid    = 1'b0;
    read_cmd       = 1'b0;
    write_cmd      = 1'b0;
    op_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        host_cmd_ready = 1'b1;
        if (host_cmd_valid) w_state_next = host_cmd_write ? S_FILL : S_ISSUE_R;
      end
      S_FILL: begin
        host_wready = !w_full;
        if (w_wr_beat && w_ptr_last) w_state_next = S_ISSUE_W;
      end
      // The engine double-synchronises the command, so hold it until it reports busy.
      S_ISSUE_W: begin
        write_cmd = 1'b1;
        if (!command_ready) w_state_next = S_WAIT_W;
      end
      S_ISSUE_R: begin
        read_cmd = 1'b1;
        if (!command_ready) w_state_next = S_WAIT_R;
      end
      S_WAIT_W: if (command_ready) w_state_next = S_DONE;
      S_WAIT_R: if (command_ready) w_state_next = S_DRAIN;
      S_DRAIN: begin
        host_rvalid = !w_full;
        if (w_rd_beat && w_ptr_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        op_done      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ramclk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr           <= '0;
      r_block_address <= '0;
      r_op_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (host_cmd_valid) begin
            r_block_address <= host_block_addr;
            r_op_error      <= 1'b0;
            r_ptr           <= '0;
          end
        end
        S_FILL: begin
          if (w_wr_beat) r_ptr <= w_ptr_last ? '0 : r_ptr + LP_ONE;
        end
        S_WAIT_W: begin
          if (write_data_enable) begin
            if (w_full) r_op_error <= 1'b1;
            else        r_ptr      <= r_ptr + LP_ONE;
          end
          if (command_ready && (r_ptr != LP_FULL)) r_op_error <= 1'b1;
        end
        S_WAIT_R: begin
          if (read_data_enable) begin
            if (w_full) r_op_error <= 1'b1;
            else        r_ptr      <= r_ptr + LP_ONE;
          end
          if (command_ready) begin
            if (r_ptr != LP_FULL) r_op_error <= 1'b1;
            r_ptr <= '0;
          end
        end
        S_DRAIN: begin
          if (w_rd_beat) r_ptr <= r_ptr + LP_ONE;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the block RAM has no reset; its contents are undefined until written.
  always_ff @(posedge ramclk) begin
    if (w_wr_beat)       r_mem[r_ptr[AW-1:0]] <= host_wdata;
    else if (w_rd_store) r_mem[r_ptr[AW-1:0]] <= read_data;
  end

  assign write_data    = r_mem[r_ptr[AW-1:0]];
  assign host_rdata    = r_mem[r_ptr[AW-1:0]];
  assign block_address = r_block_address;
  assign op_error      = r_op_error;

endmodule

// File: tb/tb_ramdisk_block_buffer.sv
// Bench for ramdisk_block_buffer: directed block writes/reads against a queue-based
// model of the words that must cross each interface, plus error and reset cases.
module tb_ramdisk_block_buffer;

  localparam int WORDS = 256;

  logic        ramclk = 1'b0;
  logic        reset_n;
  logic        host_cmd_valid, host_cmd_write;
  logic [31:0] host_block_addr;
  logic        host_cmd_ready;
  logic [15:0] host_wdata;
  logic        host_wvalid, host_wready;
  logic [15:0] host_rdata;
  logic        host_rvalid, host_rready;
  logic        op_done, op_error;
  logic        command_ready, read_cmd, write_cmd;
  logic [31:0] block_address;
  logic [15:0] write_data;
  logic        write_data_enable;
  logic [15:0] read_data;
  logic        read_data_enable;

  always #5 ramclk = ~ramclk;

  ramdisk_block_buffer #(.WORDS(WORDS), .AW(8)) dut (
    .ramclk            (ramclk),
    .reset_n           (reset_n),
    .host_cmd_valid    (host_cmd_valid),
    .host_cmd_write    (host_cmd_write),
    .host_block_addr   (host_block_addr),
    .host_cmd_ready    (host_cmd_ready),
    .host_wdata        (host_wdata),
    .host_wvalid       (host_wvalid),
    .host_wready       (host_wready),
    .host_rdata        (host_rdata),
    .host_rvalid       (host_rvalid),
    .host_rready       (host_rready),
    .op_done           (op_done),
    .op_error          (op_error),
    .command_ready     (command_ready),
    .read_cmd          (read_cmd),
    .write_cmd         (write_cmd),
    .block_address     (block_address),
    .write_data        (write_data),
    .write_data_enable (write_data_enable),
    .read_data         (read_data),
    .read_data_enable  (read_data_enable)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: words that must come out of each interface, in order, plus expected status.
  logic [15:0] exp_wq[$];
  logic [15:0] exp_rq[$];
  logic [31:0] m_addr        = '0;
  logic        m_exp_err     = 1'b0;
  logic        m_pull_active = 1'b0;
  logic        m_cmd_dropped = 1'b0;
  int          n_reassert    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    logic        prev_stall;
    logic [15:0] prev_rdata;
    prev_stall = 1'b0;
    prev_rdata = '0;
    forever begin
      @(negedge ramclk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        check("cmd_exclusive", 32'(read_cmd & write_cmd), 32'd0);
        check("block_address", block_address, m_addr);
        if (m_cmd_dropped && (read_cmd || write_cmd)) n_reassert++;
        if (prev_stall) begin
          check("rvalid_hold", 32'(host_rvalid), 32'd1);
          check("rdata_hold", 32'(host_rdata), 32'(prev_rdata));
        end
        prev_stall = host_rvalid && !host_rready;
        prev_rdata = host_rdata;
        if (host_rvalid && host_rready && exp_rq.size() > 0)
          check("host_rdata", 32'(host_rdata), 32'(exp_rq.pop_front()));
        if (write_data_enable && m_pull_active && exp_wq.size() > 0)
          check("write_data", 32'(write_data), 32'(exp_wq.pop_front()));
        if (op_done) begin
          check("op_error_model", 32'(op_error), 32'(m_exp_err));
          check("cmd_reassert", 32'(n_reassert), 32'd0);
        end
      end
    end
  end

  task automatic idle_inputs();
    host_cmd_valid    = 1'b0;
    host_cmd_write    = 1'b0;
    host_block_addr   = '0;
    host_wdata        = '0;
    host_wvalid       = 1'b0;
    host_rready       = 1'b0;
    command_ready     = 1'b1;
    write_data_enable = 1'b0;
    read_data         = '0;
    read_data_enable  = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_cmd_ready", 32'(host_cmd_ready), 32'd1);
    check("rst_wready", 32'(host_wready), 32'd0);
    check("rst_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_read_cmd", 32'(read_cmd), 32'd0);
    check("rst_write_cmd", 32'(write_cmd), 32'd0);
    check("rst_op_done", 32'(op_done), 32'd0);
    check("rst_op_error", 32'(op_error), 32'd0);
    check("rst_block_address", block_address, 32'd0);
  endtask

  task automatic reset_mid();
    reset_n = 1'b0;
    #1;
    check_reset_values();
    exp_wq.delete();
    exp_rq.delete();
    m_addr        = '0;
    m_exp_err     = 1'b0;
    m_pull_active = 1'b0;
    m_cmd_dropped = 1'b0;
    idle_inputs();
    @(posedge ramclk); #1;
    reset_n = 1'b1;
    @(posedge ramclk); #1;
  endtask

  task automatic host_cmd(input logic wr, input logic [31:0] addr);
    host_cmd_valid  = 1'b1;
    host_cmd_write  = wr;
    host_block_addr = addr;
    @(negedge ramclk);
    check("cmd_ready_idle", 32'(host_cmd_ready), 32'd1);
    @(posedge ramclk); #1;
    host_cmd_valid = 1'b0;
    m_addr         = addr;
    m_cmd_dropped  = 1'b0;
    n_reassert     = 0;
    if (wr) check("fill_wready", 32'(host_wready), 32'd1);
    else    check("read_cmd_latency", 32'(read_cmd), 32'd1);
  endtask

  task automatic host_fill(input logic [15:0] base, input int n, input logic stray);
    int k;
    for (int i = 0; i < n; i++) begin
      host_wvalid = 1'b1;
      host_wdata  = base + 16'(i);
      if (stray && i < 4) begin
        write_data_enable = 1'b1;
        read_data_enable  = 1'b1;
        read_data         = 16'hDEAD;
      end
      k = 0;
      @(negedge ramclk);
      while (!host_wready && k < 20) begin
        @(negedge ramclk);
        k++;
      end
      if (!host_wready) begin
        check("fill_wready_timeout", 32'(host_wready), 32'd1);
        break;
      end
      exp_wq.push_back(host_wdata);
      @(posedge ramclk); #1;
      write_data_enable = 1'b0;
      read_data_enable  = 1'b0;
    end
    host_wvalid = 1'b0;
    if (n == WORDS) begin
      check("write_cmd_latency", 32'(write_cmd), 32'd1);
      check("fill_wready_low", 32'(host_wready), 32'd0);
    end
  endtask

  task automatic eng_write(input int n_pull, input int hold);
    int k;
    k = 0;
    while (!write_cmd && k < 20) begin
      @(posedge ramclk); #1;
      k++;
    end
    check("write_cmd_seen", 32'(write_cmd), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge ramclk); #1;
      check("write_cmd_hold", 32'(write_cmd), 32'd1);
    end
    command_ready = 1'b0;
    @(posedge ramclk); #1;
    check("write_cmd_drop", 32'(write_cmd), 32'd0);
    m_cmd_dropped = 1'b1;
    m_pull_active = 1'b1;
    m_exp_err     = (n_pull != WORDS);
    for (int i = 0; i < n_pull; i++) begin
      if (i % 5 == 3) begin
        write_data_enable = 1'b0;
        @(posedge ramclk); #1;
      end
      write_data_enable = 1'b1;
      @(posedge ramclk); #1;
    end
    write_data_enable = 1'b0;
    m_pull_active     = 1'b0;
    @(posedge ramclk); #1;
    command_ready = 1'b1;
  endtask

  task automatic eng_read(input logic [15:0] base, input int n_push, input int hold,
                          input logic finish);
    for (int h = 0; h < hold; h++) begin
      @(posedge ramclk); #1;
      check("read_cmd_hold", 32'(read_cmd), 32'd1);
    end
    command_ready = 1'b0;
    @(posedge ramclk); #1;
    check("read_cmd_drop", 32'(read_cmd), 32'd0);
    m_cmd_dropped = 1'b1;
    m_exp_err     = (n_push != WORDS);
    for (int i = 0; i < n_push; i++) begin
      if (i % 7 == 2) begin
        read_data_enable = 1'b0;
        @(posedge ramclk); #1;
      end
      read_data_enable = 1'b1;
      read_data        = base + 16'(i);
      if (i < WORDS) exp_rq.push_back(read_data);
      @(posedge ramclk); #1;
    end
    read_data_enable = 1'b0;
    if (finish) begin
      @(posedge ramclk); #1;
      command_ready = 1'b1;
      @(posedge ramclk); #1;
    end
  endtask

  task automatic drain(input logic [15:0] first_word);
    int k;
    int beats;
    int cyc;
    k = 0;
    @(negedge ramclk);
    while (!host_rvalid && k < 10) begin
      @(negedge ramclk);
      k++;
    end
    check("drain_rvalid", 32'(host_rvalid), 32'd1);
    check("drain_first_word", 32'(host_rdata), 32'(first_word));
    beats = 0;
    cyc   = 0;
    while (beats < WORDS && cyc < 3000) begin
      @(posedge ramclk); #1;
      host_rready = (cyc % 2 == 1);
      @(negedge ramclk);
      if (host_rvalid && host_rready) beats++;
      cyc++;
    end
    check("drain_beats", 32'(beats), 32'(WORDS));
    @(posedge ramclk); #1;
    host_rready = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err);
    int k;
    k = 0;
    @(negedge ramclk);
    while (!op_done && k < 100) begin
      @(negedge ramclk);
      k++;
    end
    check("op_done_seen", 32'(op_done), 32'd1);
    check("op_error", 32'(op_error), 32'(exp_err));
    check("done_rvalid_low", 32'(host_rvalid), 32'd0);
    @(posedge ramclk); #1;
    check("op_done_pulse", 32'(op_done), 32'd0);
    check("idle_cmd_ready", 32'(host_cmd_ready), 32'd1);
    check("op_error_held", 32'(op_error), 32'(exp_err));
    m_cmd_dropped = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    reset_n = 1'b0;
    idle_inputs();
    #3;
    check_reset_values();
    @(posedge ramclk); #1;
    reset_n = 1'b1;
    @(posedge ramclk); #1;

    // Block write 0x0000..0x00FF to block 0x12, pulled with gaps.
    host_cmd(1'b1, 32'h12);
    host_fill(16'h0000, WORDS, 1'b0);
    eng_write(WORDS, 3);
    wait_done(1'b0);
    check("wr_block_address", block_address, 32'h12);

    // Block read 0xA000.. from block 7 with a 5-cycle command hold.
    host_cmd(1'b0, 32'h7);
    eng_read(16'hA000, WORDS, 5, 1'b1);
    drain(16'hA000);
    wait_done(1'b0);
    check("rd_block_address", block_address, 32'h7);

    // Short read: 255 words still drain 256 beats and flag an error.
    host_cmd(1'b0, 32'h8);
    eng_read(16'hB000, WORDS - 1, 2, 1'b1);
    drain(16'hB000);
    wait_done(1'b1);

    // Read overrun: 257th word is discarded.
    host_cmd(1'b0, 32'h9);
    eng_read(16'hD000, WORDS + 1, 2, 1'b1);
    drain(16'hD000);
    wait_done(1'b1);

    // Write overrun: engine pulls 257 words.
    host_cmd(1'b1, 32'hA);
    host_fill(16'h5500, WORDS, 1'b0);
    eng_write(WORDS + 1, 2);
    wait_done(1'b1);

    // Reset after 100 host words.
    host_cmd(1'b1, 32'h33);
    host_fill(16'h7000, 100, 1'b0);
    reset_mid();

    // Reset in WAIT_R while an overrun error is already latched.
    host_cmd(1'b0, 32'h55);
    eng_read(16'hC000, WORDS + 1, 2, 1'b0);
    check("wait_r_err_live", 32'(op_error), 32'd1);
    reset_mid();

    // Fresh write after reset, with stray engine enables during FILL.
    host_cmd(1'b1, 32'h99);
    host_fill(16'h1000, WORDS, 1'b1);
    eng_write(WORDS, 2);
    wait_done(1'b0);
    check("final_block_address", block_address, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
